// File: rtl/alg_dm_cmd_arbiter.sv
// alg_dm_cmd_arbiter
//   Shares one AXI datamover MM2S command port between two requesters and
//   routes the returning status words back to whichever requester issued the
//   matching command.
//
//   Each issued command carries a 4-bit tag {requester id, 3-bit issue count}
//   in tdata[67:64]. Issued tags are queued in order, and the head of that
//   queue decides where the next status word goes. The queue is MAX_OUTST
//   deep, and the arbiter stalls while it is full.
//
// Ports
//   clk, rst                   rising-edge clock, synchronous active-high reset
//   s0_axis_cmd_*              requester 0 command (72-bit tdata)
//   s1_axis_cmd_*              requester 1 command (72-bit tdata)
//   m_axis_mm2s_cmd_*          shared datamover command (tag inserted)
//   s_axis_mm2s_sts_*          datamover status ([7] OKAY, [6:4] err, [3:0] tag)
//   m0_sts_*, m1_sts_*         status routed to requester 0 / 1
//   clr_err                    clears the sticky error flags
//   err_status                 sticky: status reported not-OKAY or error bits
//   err_tag                    sticky: status tag differed from expected tag
//   err_orphan                 sticky: status arrived with nothing in flight
//   outst_cnt                  commands issued and awaiting status

module alg_dm_cmd_arbiter #(
  parameter int unsigned MAX_OUTST = 4
) (
  input  logic        clk,
  input  logic        rst,

  input  logic [71:0] s0_axis_cmd_tdata,
  input  logic        s0_axis_cmd_tvalid,
  output logic        s0_axis_cmd_tready,

  input  logic [71:0] s1_axis_cmd_tdata,
  input  logic        s1_axis_cmd_tvalid,
  output logic        s1_axis_cmd_tready,

  output logic [71:0] m_axis_mm2s_cmd_tdata,
  output logic        m_axis_mm2s_cmd_tvalid,
  input  logic        m_axis_mm2s_cmd_tready,

  input  logic [7:0]  s_axis_mm2s_sts_tdata,
  input  logic        s_axis_mm2s_sts_tvalid,
  output logic        s_axis_mm2s_sts_tready,

  output logic [7:0]  m0_sts_tdata,
  output logic        m0_sts_tvalid,
  input  logic        m0_sts_tready,

  output logic [7:0]  m1_sts_tdata,
  output logic        m1_sts_tvalid,
  input  logic        m1_sts_tready,

  input  logic        clr_err,
  output logic        err_status,
  output logic        err_tag,
  output logic        err_orphan,
  output logic [3:0]  outst_cnt
);

  localparam int unsigned AW = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;

  typedef enum logic {
    ARB,
    SEND
  } state_t;

  state_t      state, state_nxt;
  logic        grant, grant_nxt;
  logic        last_grant, last_grant_nxt;

  logic [2:0]  issue_cnt;
  logic [3:0]  tag_mem [MAX_OUTST];
  logic [AW-1:0] wr_ptr, rd_ptr;

  logic        any_req;
  logic        winner;
  logic        fifo_empty;
  logic        can_issue;
  logic        cmd_hs;
  logic        sts_hs;
  logic        orphan;
  logic        route;
  logic [3:0]  head_tag;
  logic [3:0]  issue_tag;
  logic [71:0] granted_tdata;
  logic        sts_bad;
  logic        tag_bad;

  // ---------------------------------------------------------------------------
  // Arbitration helpers
  // ---------------------------------------------------------------------------
  assign any_req   = s0_axis_cmd_tvalid | s1_axis_cmd_tvalid;
  assign fifo_empty = (outst_cnt == 4'd0);
  assign can_issue = (outst_cnt < 4'(MAX_OUTST));

  // On a tie, the requester that was not granted last wins. With only one
  // request, s1 wins exactly when s1 is the one asking.
  always_comb begin
    if (s0_axis_cmd_tvalid && s1_axis_cmd_tvalid) begin
      winner = ~last_grant;
    end else begin
      winner = s1_axis_cmd_tvalid;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ARB;
      grant      <= 1'b0;
      last_grant <= 1'b1;
    end else begin
      state      <= state_nxt;
      grant      <= grant_nxt;
      last_grant <= last_grant_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt      = state;
    grant_nxt      = grant;
    last_grant_nxt = last_grant;
    case (state)
      ARB: begin
        if (any_req && can_issue) begin
          state_nxt      = SEND;
          grant_nxt      = winner;
          last_grant_nxt = winner;
        end
      end
      SEND: begin
        if (m_axis_mm2s_cmd_tready) begin
          state_nxt = ARB;
        end
      end
      default: state_nxt = ARB;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  assign issue_tag = {grant, issue_cnt};

  always_comb begin
    m_axis_mm2s_cmd_tvalid = (state == SEND);
    s0_axis_cmd_tready     = (state == SEND) && !grant && m_axis_mm2s_cmd_tready;
    s1_axis_cmd_tready     = (state == SEND) &&  grant && m_axis_mm2s_cmd_tready;
    granted_tdata          = grant ? s1_axis_cmd_tdata : s0_axis_cmd_tdata;
    m_axis_mm2s_cmd_tdata  = {granted_tdata[71:68], issue_tag, granted_tdata[63:0]};
  end

  assign cmd_hs = (state == SEND) && m_axis_mm2s_cmd_tready;

  // ---------------------------------------------------------------------------
  // Status routing: the oldest outstanding tag selects the destination
  // ---------------------------------------------------------------------------
  assign head_tag = tag_mem[rd_ptr];
  assign route    = head_tag[3];

  always_comb begin
    m0_sts_tdata  = s_axis_mm2s_sts_tdata;
    m1_sts_tdata  = s_axis_mm2s_sts_tdata;
    m0_sts_tvalid = 1'b0;
    m1_sts_tvalid = 1'b0;
    if (fifo_empty) begin
      // Nothing in flight: sink the word so a stray status cannot wedge the bus.
      s_axis_mm2s_sts_tready = 1'b1;
    end else begin
      s_axis_mm2s_sts_tready = route ? m1_sts_tready : m0_sts_tready;
      m0_sts_tvalid          = s_axis_mm2s_sts_tvalid && !route;
      m1_sts_tvalid          = s_axis_mm2s_sts_tvalid &&  route;
    end
  end

  assign sts_hs  = s_axis_mm2s_sts_tvalid && s_axis_mm2s_sts_tready && !fifo_empty;
  assign orphan  = s_axis_mm2s_sts_tvalid && fifo_empty;
  assign sts_bad = sts_hs && (!s_axis_mm2s_sts_tdata[7] || (s_axis_mm2s_sts_tdata[6:4] != 3'b000));
  assign tag_bad = sts_hs && (s_axis_mm2s_sts_tdata[3:0] != head_tag);

  // ---------------------------------------------------------------------------
  // Issue counter, tag FIFO pointers and occupancy
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      issue_cnt <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      outst_cnt <= '0;
    end else begin
      if (cmd_hs) begin
        issue_cnt <= issue_cnt + 3'd1;
        wr_ptr    <= wr_ptr + 1'b1;
      end
      if (sts_hs) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({cmd_hs, sts_hs})
        2'b10:   outst_cnt <= outst_cnt + 4'd1;
        2'b01:   outst_cnt <= outst_cnt - 4'd1;
        default: outst_cnt <= outst_cnt;
      endcase
    end
  end

  // Tag storage needs no reset: entries are only read once written.
  always_ff @(posedge clk) begin
    if (cmd_hs) begin
      tag_mem[wr_ptr] <= issue_tag;
    end
  end

  // ---------------------------------------------------------------------------
  // Sticky error flags; a new error in the clearing cycle stays visible
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      err_status <= 1'b0;
      err_tag    <= 1'b0;
      err_orphan <= 1'b0;
    end else begin
      if (sts_bad)      err_status <= 1'b1;
      else if (clr_err) err_status <= 1'b0;

      if (tag_bad)      err_tag <= 1'b1;
      else if (clr_err) err_tag <= 1'b0;

      if (orphan)       err_orphan <= 1'b1;
      else if (clr_err) err_orphan <= 1'b0;
    end
  end

endmodule

// File: doc/alg_dm_cmd_arbiter.md
ALG_DM_CMD_ARBITER -- requirements
Module: alg_dm_cmd_arbiter

Interface
REQ-001 The block SHALL have parameter MAX_OUTST, default 4, meaning max commands issued without status returned (legal 2..8, power of 2).
REQ-002 The block SHALL have port clk  input  1  sole clock, all logic rising-edge.
REQ-003 The block SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 The block SHALL have ports s0_axis_cmd_tdata/tvalid/tready  in/in/out  72/1/1  requester 0 datamover command.
REQ-005 The block SHALL have ports s1_axis_cmd_tdata/tvalid/tready  in/in/out  72/1/1  requester 1 datamover command.
REQ-006 The block SHALL have ports m_axis_mm2s_cmd_tdata/tvalid/tready  out/out/in  72/1/1  shared datamover MM2S command.
REQ-007 The block SHALL have ports s_axis_mm2s_sts_tdata/tvalid/tready  in/in/out  8/1/1  datamover status ([7] OKAY, [6:4] errors, [3:0] TAG).
REQ-008 The block SHALL have ports m0_sts_tdata/tvalid/tready and m1_sts_tdata/tvalid/tready  out/out/in  8/1/1  routed status per requester.
REQ-009 The block SHALL have ports clr_err  input  1  clears sticky errors; err_status, err_tag, err_orphan  output  1 each  sticky flags; outst_cnt  output  4  commands in flight.

Function
REQ-010 The arbiter SHALL have states ARB and SEND; in ARB, grant only if some request is valid and outst_cnt < MAX_OUTST, then go to SEND next cycle.
REQ-011 Arbitration SHALL be round-robin: single requester valid -> it wins; both valid -> the one not granted last; last-grant pointer resets to 1, so requester 0 wins the first tie.
REQ-012 Grant SHALL be held through SEND until m_axis_mm2s_cmd handshake (tvalid&tready), then return to ARB: one command per 2 cycles max.
REQ-013 m_axis_mm2s_cmd_tvalid SHALL equal (state==SEND); sN_axis_cmd_tready SHALL equal (state==SEND)&&(grant==N)&&m_axis_mm2s_cmd_tready; the non-granted tready is 0.
REQ-014 m_axis_mm2s_cmd_tdata SHALL be granted tdata with bits [67:64] replaced by tag {grant id, 3-bit issue counter}; all other bits pass unchanged.
REQ-015 Issue counter SHALL increment mod 8 on every command handshake.
REQ-016 An in-order tag FIFO of depth MAX_OUTST SHALL push the issued 4-bit tag on command handshake and pop on status handshake; push and pop in the same cycle are both honoured.
REQ-017 outst_cnt SHALL be +1 on command handshake only, -1 on status handshake only, unchanged when both or neither; never exceeds MAX_OUTST.
REQ-018 With FIFO non-empty, status SHALL route to requester tag[3] of the FIFO head: that mN_sts_tvalid = s_axis_mm2s_sts_tvalid, mN_sts_tdata = sts tdata, s_axis_mm2s_sts_tready = mN_sts_tready; the other mN_sts_tvalid is 0.
REQ-019 Status handshake with sts tdata[3:0] != FIFO head tag SHALL set err_tag; the status is still routed by the FIFO head.
REQ-020 Status handshake with sts tdata[7]==0 or any of [6:4] set SHALL set err_status.
REQ-021 With FIFO empty, s_axis_mm2s_sts_tready SHALL be 1, status is dropped, and err_orphan is set on tvalid; outst_cnt stays 0.
REQ-022 Sticky flags SHALL clear on clr_err; a set event coinciding with clr_err SHALL win.
REQ-023 A full FIFO (outst_cnt==MAX_OUTST) SHALL hold the arbiter in ARB with all cmd treadys 0 until a status pops.

Reset
REQ-024 On rst SHALL: state=ARB, last grant=1, issue counter=0, FIFO empty, outst_cnt=0, all err flags 0, m_axis_mm2s_cmd_tvalid=0, all sN tready=0; mid-SEND reset drops the command without handshake.

Verification
REQ-025 Only s0 valid, tdata=0x..00400 (len 1024), m tready=1 -> m tvalid 1 cycle after, tag 0x0, s0 tready pulses once, outst_cnt=1.
REQ-026 s0,s1 valid continuously, m tready=1, status back-to-back OKAY -> grants alternate 0,1,0,1; tags 0x0,0x9,0x2,0xB.
REQ-027 MAX_OUTST=4, no status returned, 6 requests -> exactly 4 issued, arbiter stalls, outst_cnt=4; one status returns -> 5th issues.
REQ-028 Status 0x80|tag routed to m1 while m1_sts_tready=0 -> s_axis_mm2s_sts_tready=0, status held, then delivered when tready rises.
REQ-029 Status 0x40 with wrong tag -> err_status=1, err_tag=1; orphan status with FIFO empty -> err_orphan=1; clr_err -> all 0.
REQ-030 rst asserted during SEND with m tready=0 -> next cycle tvalid=0, outst_cnt=0, first post-reset tie grants s0.
